// File: rtl/async_fifo_rd_pkg.sv
// rtl/async_fifo_rd_pkg.sv - shared state type and width helpers for the FIFO read streamer
package async_fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int beat_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - small circular output buffer with push/pop, head data and occupancy
module stream_skid_buf
    import async_fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW   = ptr_width(DEPTH),
    localparam int CW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Storage is not reset, so an empty buffer presents zero rather than stale data.
    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/async_fifo_rd_streamer.sv
// rtl/async_fifo_rd_streamer.sv - FIFO read-port consumer re-presenting data as a framed valid/ready stream
// Optional beat counter output rd_count_o when ASYNC_FIFO_RD_STATS_EN is defined.
module async_fifo_rd_streamer
    import async_fifo_rd_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2,
    parameter int BURST_LEN = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    output logic             rd_en_o,
    input  logic [WIDTH-1:0] rdata_i,
    input  logic             empty_i,
    input  logic             rd_error_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             err_o
`ifdef ASYNC_FIFO_RD_STATS_EN
    ,
    output logic [31:0]      rd_count_o
`endif
);

    localparam int CW = count_width(BUF_DEPTH);
    localparam int BW = beat_width(BURST_LEN);

    state_t         state;
    state_t         state_next;
    logic           inflight;
    logic [CW-1:0]  count;
    logic [BW-1:0]  beat;
    logic           pop;
    logic           push;
    logic [CW:0]    occ;

    assign pop  = m_valid_o & m_ready_i;
    assign push = inflight & ~rd_error_i;

    // Occupancy counts the read already in flight and credits a same-cycle pop.
    assign occ     = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign rd_en_o = (state == RUN) & enable_i & ~empty_i & (occ < (CW+1)'(BUF_DEPTH));

    assign m_valid_o = (count != '0);
    assign m_last_o  = m_valid_o & (beat == BW'(BURST_LEN - 1));
    assign busy_o    = (state != IDLE);

    stream_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (push),
        .push_data (rdata_i),
        .pop       (pop),
        .head_data (m_data_o),
        .count     (count)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            inflight <= 1'b0;
            err_o    <= 1'b0;
            beat     <= '0;
        end else begin
            state    <= state_next;
            inflight <= rd_en_o;
            if (inflight & rd_error_i) err_o <= 1'b1;
            if (pop) beat <= (beat == BW'(BURST_LEN - 1)) ? '0 : beat + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_i) state_next = RUN;
            RUN:     if (!enable_i) state_next = DRAIN;
            DRAIN: begin
                if (enable_i)                          state_next = RUN;
                else if ((count == '0) && !inflight)   state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ASYNC_FIFO_RD_STATS_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  rd_count_o <= 32'd0;
        else if (pop)  rd_count_o <= rd_count_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_async_fifo_rd_streamer.sv
// tb/tb_async_fifo_rd_streamer.sv - randomized bench for async_fifo_rd_streamer against a queue-based FIFO/stream model
module tb_async_fifo_rd_streamer;

    localparam int W     = 8;
    localparam int DEPTH = 2;
    localparam int BURST = 4;

    logic         clk = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         enable_i = 1'b0;
    logic         rd_en_o;
    logic [W-1:0] rdata_i = '0;
    logic         empty_i = 1'b1;
    logic         rd_error_i = 1'b0;
    logic [W-1:0] m_data_o;
    logic         m_valid_o;
    logic         m_ready_i = 1'b0;
    logic         m_last_o;
    logic         busy_o;
    logic         err_o;
`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [31:0]  rd_count_o;
`endif

    async_fifo_rd_streamer #(
        .WIDTH     (W),
        .BUF_DEPTH (DEPTH),
        .BURST_LEN (BURST)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .enable_i   (enable_i),
        .rd_en_o    (rd_en_o),
        .rdata_i    (rdata_i),
        .empty_i    (empty_i),
        .rd_error_i (rd_error_i),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_last_o   (m_last_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
`ifdef ASYNC_FIFO_RD_STATS_EN
        ,
        .rd_count_o (rd_count_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model: the FIFO contents, the beats the streamer holds, and stream framing.
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    bit           inflight_m = 0;
    bit           err_m = 0;
    int           beat_m = 0;
    int           pops = 0;
    int           cyc = 0;
    int unsigned  pop_total = 0;
    bit           inject_err = 0;
    bit           noise_en = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    logic         s_rd_en, s_pop, s_last;

    task automatic clear_model();
        exp_q.delete();
        inflight_m = 0;
        err_m      = 0;
        beat_m     = 0;
        pop_total  = 0;
        prev_stall = 0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(W'($urandom));
        empty_i = (fifo_q.size() == 0);
    endtask

    task automatic step();
        logic         push_now, err_now;
        logic [W-1:0] push_val;
        @(negedge clk);
        s_rd_en = rd_en_o;
        s_pop   = m_valid_o & m_ready_i;
        s_last  = m_last_o;
        checks++;
        if (s_rd_en && empty_i) $display("FAIL rd_en_empty cyc=%0d rd_en=%b empty=%b", cyc, s_rd_en, empty_i);
        else passed++;
        checks++;
        if (m_valid_o !== (exp_q.size() != 0)) $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, m_valid_o, exp_q.size() != 0);
        else passed++;
        if (exp_q.size() != 0) begin
            checks++;
            if (m_data_o !== exp_q[0]) $display("FAIL data cyc=%0d got=%h exp=%h", cyc, m_data_o, exp_q[0]);
            else passed++;
        end
        if (prev_stall) begin
            checks++;
            if (m_data_o !== prev_data || m_valid_o !== 1'b1) $display("FAIL hold cyc=%0d got=%h/%b exp=%h/1", cyc, m_data_o, m_valid_o, prev_data);
            else passed++;
        end
        checks++;
        if (m_last_o !== (exp_q.size() != 0 && beat_m == BURST - 1)) $display("FAIL last cyc=%0d got=%b beat=%0d", cyc, m_last_o, beat_m);
        else passed++;
        checks++;
        if (err_o !== err_m) $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err_o, err_m);
        else passed++;
        checks++;
        if (exp_q.size() + inflight_m > DEPTH) $display("FAIL overflow cyc=%0d held=%0d inflight=%0d max=%0d", cyc, exp_q.size(), inflight_m, DEPTH);
        else passed++;
`ifdef ASYNC_FIFO_RD_STATS_EN
        checks++;
        if (rd_count_o !== pop_total) $display("FAIL rd_count cyc=%0d got=%0d exp=%0d", cyc, rd_count_o, pop_total);
        else passed++;
`endif
        prev_stall = m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
        push_now   = inflight_m && !rd_error_i;
        err_now    = inflight_m && rd_error_i;
        push_val   = rdata_i;
        if (s_pop) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            beat_m = (beat_m == BURST - 1) ? 0 : beat_m + 1;
            pops++;
            pop_total++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (push_now) exp_q.push_back(push_val);
        if (err_now) err_m = 1;
        inflight_m = s_rd_en;
        if (s_rd_en && fifo_q.size() != 0) rdata_i = fifo_q.pop_front();
        empty_i = (fifo_q.size() == 0);
        if (s_rd_en && inject_err) begin
            rd_error_i = 1'b1;
            inject_err = 0;
        end else if (!s_rd_en && noise_en) rd_error_i = 1'($urandom_range(0, 1));
        else rd_error_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i    = 1'b0;
        enable_i   = 1'b0;
        m_ready_i  = 1'b0;
        rd_error_i = 1'b0;
        noise_en   = 0;
        inject_err = 0;
        repeat (2) @(posedge clk);
        clear_model();
        @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        load(3);
        enable_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 6;
        if (rd_en_o !== 1'b0)   $display("FAIL reset_rd_en got=%b exp=0", rd_en_o);     else passed++;
        if (m_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", m_valid_o);   else passed++;
        if (m_last_o !== 1'b0)  $display("FAIL reset_last got=%b exp=0", m_last_o);     else passed++;
        if (busy_o !== 1'b0)    $display("FAIL reset_busy got=%b exp=0", busy_o);       else passed++;
        if (err_o !== 1'b0)     $display("FAIL reset_err got=%b exp=0", err_o);         else passed++;
        if (m_data_o !== '0)    $display("FAIL reset_data got=%h exp=0", m_data_o);     else passed++;
        fifo_q.delete();
        empty_i = 1'b1;
        do_reset();
        step();
        checks++;
        if (busy_o !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy_o); else passed++;
    endtask

    task automatic test_stream();
        int first_pop, last_pop;
        do_reset();
        for (int i = 1; i <= 5; i++) fifo_q.push_back(W'(i));
        empty_i   = 1'b0;
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        pops      = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int i = 0; i < 40 && pops < 5; i++) begin
            step();
            if (s_pop) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        checks += 3;
        if (pops !== 5) $display("FAIL stream_count got=%0d exp=5", pops); else passed++;
        if (last_pop - first_pop !== 4) $display("FAIL stream_throughput span=%0d exp=4", last_pop - first_pop); else passed++;
        if (err_o !== 1'b0) $display("FAIL stream_err got=%b exp=0", err_o); else passed++;
    endtask

    task automatic test_burst();
        int last_mask;
        do_reset();
        load(10);
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        pops      = 0;
        last_mask = 0;
        for (int i = 0; i < 60 && pops < 10; i++) begin
            step();
            if (s_pop && s_last) last_mask |= 1 << (pops - 1);
        end
        checks++;
        if (last_mask !== 32'h88) $display("FAIL burst_last_mask got=%h exp=88", last_mask); else passed++;
        load(2);
        for (int i = 0; i < 30 && pops < 12; i++) begin
            step();
            if (s_pop && s_last) last_mask |= 1 << (pops - 1);
        end
        checks++;
        if (last_mask !== 32'h888) $display("FAIL burst_wrap_mask got=%h exp=888", last_mask); else passed++;
    endtask

    task automatic test_back_pressure();
        int reads;
        do_reset();
        load(8);
        enable_i  = 1'b1;
        m_ready_i = 1'b0;
        reads     = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_rd_en) reads++;
        end
        checks += 2;
        if (reads > DEPTH || reads == 0) $display("FAIL bp_reads got=%0d max=%0d", reads, DEPTH); else passed++;
        if (m_valid_o !== 1'b1) $display("FAIL bp_valid got=%b exp=1", m_valid_o); else passed++;
        m_ready_i = 1'b1;
        pops      = 0;
        for (int i = 0; i < 40 && pops < 8; i++) step();
        checks += 2;
        if (pops !== 8) $display("FAIL bp_count got=%0d exp=8", pops); else passed++;
        if (exp_q.size() != 0 || fifo_q.size() != 0) $display("FAIL bp_leftover held=%0d fifo=%0d exp=0", exp_q.size(), fifo_q.size()); else passed++;
    endtask

    task automatic test_drain();
        int  extra_reads, guard;
        bit  saw_busy;
        do_reset();
        load(6);
        enable_i  = 1'b1;
        m_ready_i = 1'b0;
        guard     = 0;
        while (!(exp_q.size() == 1 && inflight_m) && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 20) $display("FAIL drain_setup timeout held=%0d inflight=%0d", exp_q.size(), inflight_m); else passed++;
        enable_i    = 1'b0;
        m_ready_i   = 1'b1;
        pops        = 0;
        extra_reads = 0;
        step();
        if (s_rd_en) extra_reads++;
        saw_busy = busy_o;
        for (int i = 0; i < 20 && busy_o; i++) begin
            step();
            if (s_rd_en) extra_reads++;
        end
        checks += 5;
        if (saw_busy !== 1'b1) $display("FAIL drain_busy got=%b exp=1", saw_busy); else passed++;
        if (extra_reads !== 0) $display("FAIL drain_reads got=%0d exp=0", extra_reads); else passed++;
        if (pops !== 2) $display("FAIL drain_beats got=%0d exp=2", pops); else passed++;
        if (busy_o !== 1'b0) $display("FAIL drain_idle got=%b exp=0", busy_o); else passed++;
        if (fifo_q.size() !== 4) $display("FAIL drain_fifo got=%0d exp=4", fifo_q.size()); else passed++;
        fifo_q.delete();
        empty_i = 1'b1;
    endtask

    task automatic test_rd_error();
        do_reset();
        load(6);
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        pops      = 0;
        repeat (3) step();
        inject_err = 1;
        for (int i = 0; i < 40 && (fifo_q.size() != 0 || exp_q.size() != 0 || inflight_m); i++) step();
        repeat (3) step();
        checks += 2;
        if (pops !== 5) $display("FAIL err_beats got=%0d exp=5", pops); else passed++;
        if (err_o !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err_o); else passed++;
        do_reset();
        checks++;
        if (err_o !== 1'b0) $display("FAIL err_clear got=%b exp=0", err_o); else passed++;
    endtask

    task automatic test_async_reset();
        int remaining;
        do_reset();
        load(12);
        enable_i = 1'b1;
        noise_en = 1;
        for (int i = 0; i < 8; i++) begin
            m_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        #3;
        rst_n_i = 1'b0;
        #1;
        checks += 6;
        if (rd_en_o !== 1'b0)   $display("FAIL areset_rd_en got=%b exp=0", rd_en_o);   else passed++;
        if (m_valid_o !== 1'b0) $display("FAIL areset_valid got=%b exp=0", m_valid_o); else passed++;
        if (m_last_o !== 1'b0)  $display("FAIL areset_last got=%b exp=0", m_last_o);   else passed++;
        if (busy_o !== 1'b0)    $display("FAIL areset_busy got=%b exp=0", busy_o);     else passed++;
        if (err_o !== 1'b0)     $display("FAIL areset_err got=%b exp=0", err_o);       else passed++;
        if (m_data_o !== '0)    $display("FAIL areset_data got=%h exp=0", m_data_o);   else passed++;
        clear_model();
        rd_error_i = 1'b0;
        remaining  = fifo_q.size();
        #2;
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
        pops = 0;
        for (int i = 0; i < 200 && (fifo_q.size() != 0 || exp_q.size() != 0 || inflight_m); i++) begin
            m_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        checks++;
        if (pops !== remaining) $display("FAIL areset_resume got=%0d exp=%0d", pops, remaining); else passed++;
        noise_en = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_burst();
        test_back_pressure();
        test_drain();
        test_rd_error();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_streamer.md
Name: async_fifo_rd_streamer

Overview:
- Single-clock consumer on the read side of async_fifo.
- Drives rd_en, captures registered rdata one cycle later, and re-presents the data as a valid/ready stream with burst framing (last flag every BURST_LEN beats).
- Sits between the FIFO read port and downstream datapath logic.
- Never reads an empty FIFO, so a rd_error from the FIFO indicates a protocol fault.

Parameters:
- WIDTH, 8, data width; must match the FIFO WIDTH.
- BUF_DEPTH, 2, output buffer entries; minimum 2.
- BURST_LEN, 16, beats per burst; m_last_o is asserted on beat BURST_LEN-1; minimum 1.

Ports:
- clk_i  in  1  block clock; the same clock as the FIFO rd_clk_i.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- enable_i  in  1  permits new FIFO reads while high.
- rd_en_o  out  1  FIFO read enable.
- rdata_i  in  WIDTH  FIFO read data; valid the cycle after rd_en_o.
- empty_i  in  1  FIFO empty flag.
- rd_error_i  in  1  FIFO read-error flag; sampled the cycle after rd_en_o.
- m_data_o  out  WIDTH  stream data (head of the buffer).
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- m_last_o  out  1  final beat of the current burst.
- busy_o  out  1  high whenever state is not IDLE.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n_i=0, asynchronous): all of the following are 0 or cleared:
  - rd_en_o, m_valid_o, m_last_o, busy_o, err_o, m_data_o.
  - Buffer count, inflight flag, beat counter.
  - state=IDLE.
- Reset mid-operation drops buffered and in-flight data; no recovery.
- pop = m_valid_o & m_ready_i.
- occ = count_q + inflight_q - pop.
- rd_en_o = (state==RUN) & enable_i & !empty_i & (occ < BUF_DEPTH).
  - Combinational from m_ready_i, empty_i and enable_i.
  - Gives full throughput of one beat per cycle.
- inflight_q <= rd_en_o each cycle.
  - Cycle after inflight_q=1 with rd_error_i=0: push rdata_i into the buffer tail.
  - Cycle after inflight_q=1 with rd_error_i=1: no push; set err_o.
  - rd_error_i while inflight_q=0 is ignored.
- Buffer is FIFO-ordered.
  - Same-cycle push and pop is legal; count is unchanged.
  - Overflow is impossible by construction; an overflow is a design bug, and the bench asserts on it.
- m_valid_o = (count_q != 0).
  - m_data_o is the head entry.
  - m_data_o and m_valid_o are stable while m_valid_o & !m_ready_i.
- Beat counter:
  - Increments on pop.
  - Wraps to 0 after the BURST_LEN-1 beat.
  - m_last_o = m_valid_o & (beat == BURST_LEN-1).
  - The counter is not cleared by enable_i.
- States:
  - IDLE -> RUN when enable_i=1.
  - RUN -> DRAIN when enable_i=0.
  - DRAIN -> IDLE when count_q==0 and inflight_q==0 (no pop pending).
  - DRAIN -> RUN when enable_i=1.
  - No reads are issued in IDLE or DRAIN.
- err_o clears only on reset.

Optional Feature:
- Macro: ASYNC_FIFO_RD_STATS_EN.
- Defined: adds output rd_count_o [31:0], which counts popped beats.
  - Wraps at 2^32.
  - Resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package async_fifo_rd_pkg:
  - State enum typedef (IDLE, RUN, DRAIN).
  - Localparam helpers for pointer and count widths derived from BUF_DEPTH and BURST_LEN.
- Sub-module stream_skid_buf: BUF_DEPTH-entry output buffer, with push/pop, head data and count.

Test Plan:
1. Reset with FIFO preloaded with 0x01..0x05, enable_i=1, m_ready_i=1 → the 5 beats are accepted on consecutive cycles in order.
   - rd_en_o is never high while empty_i=1.
   - err_o stays 0.
2. BURST_LEN=4, 10 beats streamed → m_last_o is high on beats 4 and 8 only; the beat counter shows 2 after the stream.
3. m_ready_i low for 5 cycles with the FIFO holding 8 entries:
   - At most BUF_DEPTH=2 reads are issued.
   - m_data_o is held stable.
   - On release, all 8 beats arrive in order with no loss or duplication.
4. enable_i dropped while 1 read is in flight and 1 beat is buffered:
   - No further rd_en_o.
   - The 2 beats drain.
   - busy_o falls when DRAIN -> IDLE.
5. rd_error_i forced high the cycle after a rd_en_o → no beat is pushed, err_o=1 and stays 1 until rst_n_i is pulsed.
6. rst_n_i asserted mid-stream (asynchronous, not on a clock edge) → all outputs are 0 immediately; after release, streaming resumes from the FIFO's current head.
